// File: rtl/reg_file_writeback_pkg.sv
// reg_file_writeback_pkg
// Shared definitions for the write-back register file slice.
// It holds the destination-select encodings, the dump FSM state
// encoding and the default link register index.
package reg_file_writeback_pkg;

    localparam int LINK_REG = 31;

    typedef enum logic [1:0] {
        REGDST_RT   = 2'b00,
        REGDST_RD   = 2'b01,
        REGDST_LINK = 2'b10,
        REGDST_NONE = 2'b11
    } regDst_e;

    typedef enum logic [1:0] {
        DUMP_IDLE = 2'b00,
        DUMP_SEND = 2'b01,
        DUMP_DONE = 2'b10
    } dumpState_e;

endpackage

// File: rtl/reg_file_dump_ctrl.sv
// reg_file_dump_ctrl
// Sequencer for the serial register dump. It walks an index through
// every register and presents one beat per index under a valid/ready
// handshake. After the last beat is accepted, it spends one cycle in
// DONE to pulse dumpDone and then returns to IDLE.
// Ports:
//   clk, reset   - system clock and synchronous active-high reset
//   dumpStart    - request a dump (only honoured while idle)
//   dumpReady    - sink accepts the current beat
//   dumpValid    - beat valid (SEND state)
//   dumpBusy     - dump in progress (SEND or DONE)
//   dumpDone     - one-cycle pulse after the final beat
//   dumpIndex    - register index of the current beat (0 outside SEND)
import reg_file_writeback_pkg::*;

module reg_file_dump_ctrl #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dumpStart,
    input  logic              dumpReady,
    output logic              dumpValid,
    output logic              dumpBusy,
    output logic              dumpDone,
    output logic [ADDR_W-1:0] dumpIndex
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = '1;

    dumpState_e        state;
    dumpState_e        stateNext;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] indexNext;

    // State and index registers. Reset drops any dump in flight, so no
    // dumpDone is produced for an aborted dump.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DUMP_IDLE;
            index <= '0;
        end else begin
            state <= stateNext;
            index <= indexNext;
        end
    end

    // Next-state and handshake outputs. The index increment wraps
    // naturally from the last register back to 0, so the next dump
    // starts at 0 without an extra clear. dumpStart is only looked at
    // in IDLE, so a request during a dump is dropped rather than queued.
    always_comb begin
        stateNext = state;
        indexNext = index;
        dumpValid = 1'b0;
        dumpBusy  = 1'b0;
        dumpDone  = 1'b0;
        dumpIndex = '0;
        case (state)
            DUMP_IDLE: begin
                if (dumpStart) begin
                    stateNext = DUMP_SEND;
                    indexNext = '0;
                end
            end
            DUMP_SEND: begin
                dumpValid = 1'b1;
                dumpBusy  = 1'b1;
                dumpIndex = index;
                if (dumpReady) begin
                    indexNext = index + 1'b1;
                    if (index == LAST_INDEX) begin
                        stateNext = DUMP_DONE;
                    end
                end
            end
            DUMP_DONE: begin
                dumpBusy  = 1'b1;
                dumpDone  = 1'b1;
                stateNext = DUMP_IDLE;
            end
            default: begin
                stateNext = DUMP_IDLE;
                indexNext = '0;
            end
        endcase
    end

endmodule

// File: rtl/reg_file_writeback.sv
// reg_file_writeback
// Architectural register file at the write-back end of the datapath.
// The destination register is rt, rd or the link register, chosen by
// regDst. The two read ports are combinational and write-first. A serial
// dump port streams every register out under a valid/ready handshake.
// Ports:
//   clk, reset            - system clock and synchronous active-high reset
//   readReg1/2            - read port indices (rs, rt)
//   rt, rd                - instruction register fields
//   regDst                - 00 rt, 01 rd, 10 link register, 11 no write
//   regWrite, writeData   - write enable and write-back word
//   readData1/2           - read port data
//   dumpStart, dumpReady  - dump request and sink ready
//   dumpValid, dumpAddr,
//   dumpData              - current dump beat
//   dumpBusy, dumpDone    - dump status and completion pulse
import reg_file_writeback_pkg::*;

module reg_file_writeback #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LINK_REG = reg_file_writeback_pkg::LINK_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    input  logic [ADDR_W-1:0] rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic [1:0]        regDst,
    input  logic              regWrite,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic              dumpStart,
    input  logic              dumpReady,
    output logic              dumpValid,
    output logic [ADDR_W-1:0] dumpAddr,
    output logic [DATA_W-1:0] dumpData,
    output logic              dumpBusy,
    output logic              dumpDone
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [ADDR_W-1:0] wAddr;
    logic              writeEn;
    logic [ADDR_W-1:0] dumpIndex;

    // Destination decode. REGDST_NONE suppresses the write. A write to
    // register 0 is also suppressed, so register 0 keeps reading as 0.
    always_comb begin
        wAddr = '0;
        case (regDst)
            REGDST_RT:   wAddr = rt;
            REGDST_RD:   wAddr = rd;
            REGDST_LINK: wAddr = ADDR_W'(LINK_REG);
            default:     wAddr = '0;
        endcase
        writeEn = regWrite && (regDst != REGDST_NONE) && (wAddr != '0);
    end

    // Register storage. Reset takes priority over a write on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn) begin
            regs[wAddr] <= writeData;
        end
    end

    // Write-first read ports. A read of the register being written in the
    // same cycle returns the incoming word. Index 0 is forced to 0 even
    // when bypassing.
    always_comb begin
        readData1 = '0;
        readData2 = '0;
        if (readReg1 != '0) begin
            readData1 = (writeEn && readReg1 == wAddr) ? writeData : regs[readReg1];
        end
        if (readReg2 != '0) begin
            readData2 = (writeEn && readReg2 == wAddr) ? writeData : regs[readReg2];
        end
    end

    reg_file_dump_ctrl #(
        .ADDR_W (ADDR_W)
    ) uDumpCtrl (
        .clk       (clk),
        .reset     (reset),
        .dumpStart (dumpStart),
        .dumpReady (dumpReady),
        .dumpValid (dumpValid),
        .dumpBusy  (dumpBusy),
        .dumpDone  (dumpDone),
        .dumpIndex (dumpIndex)
    );

    // The dump beat shows the stored contents without bypass. A write on the
    // same edge as a transfer therefore leaves the outgoing beat unchanged.
    // During a stall, the beat picks up the new value one cycle after the
    // write lands.
    always_comb begin
        dumpAddr = dumpIndex;
        dumpData = '0;
        if (dumpValid && dumpIndex != '0) begin
            dumpData = regs[dumpIndex];
        end
    end

endmodule
